// File: rtl/riscv_pkg.sv
// Shared RV32I encoding constants: major opcodes, instruction formats and the canonical NOP.
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {FMT_U, FMT_J, FMT_I, FMT_S, FMT_B, FMT_R, FMT_BAD} fmt_e;

  typedef enum logic [1:0] {ST_LOAD, ST_DRAIN, ST_DONE} state_e;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC:          return FMT_U;
      OP_JAL:                    return FMT_J;
      OP_JALR, OP_LOAD, OP_IMM:  return FMT_I;
      OP_STORE:                  return FMT_S;
      OP_BRANCH:                 return FMT_B;
      OP_REG:                    return FMT_R;
      default:                   return FMT_BAD;
    endcase
  endfunction

endpackage

// File: rtl/imm_scatter.sv
// Combinational RV32I field packer: places the immediate per format and flags encode errors.
// Optional immediate range/alignment checks are compiled in with IMM_CHECK_EN.
module imm_scatter
  import riscv_pkg::*;
(
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic signed [31:0] imm,
  output logic [31:0]       instr,
  output logic              enc_err
);

`ifdef IMM_CHECK_EN
  // True when v is representable as an n-bit two's complement value.
  function automatic logic fits_s(input logic signed [31:0] v, input int n);
    logic signed [31:0] t;
    t = v >>> (n - 1);
    return (t == 32'sd0) || (t == -32'sd1);
  endfunction
`endif

  fmt_e fmt;
  logic is_shift;

  always_comb begin
    fmt      = fmt_of(opcode);
    is_shift = (opcode == OP_IMM) && (funct3[1:0] == 2'b01);
    instr    = NOP;
    enc_err  = 1'b0;
    case (fmt)
      FMT_U: instr = {imm[31:12], rd, opcode};
      FMT_J: instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      FMT_I: begin
        if (is_shift) instr = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        else          instr = {imm[11:0], rs1, funct3, rd, opcode};
      end
      FMT_S: instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_R: instr = {funct7, rs2, rs1, funct3, rd, opcode};
      default: enc_err = 1'b1;
    endcase
`ifdef IMM_CHECK_EN
    case (fmt)
      FMT_U: enc_err = enc_err | (imm[11:0] != 12'd0);
      FMT_J: enc_err = enc_err | !fits_s(imm, 21) | imm[0];
      FMT_I: enc_err = enc_err | (is_shift ? (imm[31:5] != 27'd0) : !fits_s(imm, 12));
      FMT_S: enc_err = enc_err | !fits_s(imm, 12);
      FMT_B: enc_err = enc_err | !fits_s(imm, 13) | imm[0];
      default: ;
    endcase
`endif
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder with a 2-entry skid buffer and sequential word addresses.
// Build option: IMM_CHECK_EN enables immediate range/alignment error checks in imm_scatter.
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int              ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         in_opcode,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [2:0]         in_funct3,
  input  logic [6:0]         in_funct7,
  input  logic signed [31:0] in_imm,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               done,
  output logic               err,
  output logic [7:0]         err_cnt
);

  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic rdy_q;
  logic [ADDR_W-1:0] addr_q;
  logic err_q;
  logic [7:0] err_cnt_q;
  logic accept, pop;

  // Stage p0: combinational encode of the offered fields.
  logic [31:0] instr_p0;
  logic        enc_err_p0;

  imm_scatter u_scatter (
    .opcode  (in_opcode),
    .rd      (in_rd),
    .rs1     (in_rs1),
    .rs2     (in_rs2),
    .funct3  (in_funct3),
    .funct7  (in_funct7),
    .imm     (in_imm),
    .instr   (instr_p0),
    .enc_err (enc_err_p0)
  );

  // Stage p1: skid buffer, entry 0 is the head presented on the output.
  logic [31:0]       instr0_p1, instr1_p1;
  logic [ADDR_W-1:0] addr0_p1, addr1_p1;

  assign in_ready  = rdy_q && !clear;
  assign accept    = in_valid && in_ready;
  assign out_valid = (cnt_q != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_instr = instr0_p1;
  assign out_addr  = addr0_p1;
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) cnt_d = 2'd0;
    else       cnt_d = cnt_q + 2'(accept) - 2'(pop);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:  if (accept && in_last) state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_q == 2'd0) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_LOAD;
    endcase
    if (clear) state_d = ST_LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      cnt_q     <= 2'd0;
      rdy_q     <= 1'b1;
      addr_q    <= BASE_ADDR;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
      instr0_p1 <= '0;
      instr1_p1 <= '0;
      addr0_p1  <= BASE_ADDR;
      addr1_p1  <= BASE_ADDR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Ready is registered from next-state occupancy so it never needs a combinational path from out_ready.
      rdy_q   <= (state_d == ST_LOAD) && (cnt_d != 2'd2);
      if (clear) begin
        addr_q    <= BASE_ADDR;
        err_q     <= 1'b0;
        err_cnt_q <= 8'd0;
      end else if (accept) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (enc_err_p0) begin
          err_q <= 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
      end
      if (!clear) begin
        case ({accept, pop})
          2'b10: begin
            if (cnt_q == 2'd0) begin
              instr0_p1 <= instr_p0;
              addr0_p1  <= addr_q;
            end else begin
              instr1_p1 <= instr_p0;
              addr1_p1  <= addr_q;
            end
          end
          2'b01: begin
            if (cnt_q == 2'd2) begin
              instr0_p1 <= instr1_p1;
              addr0_p1  <= addr1_p1;
            end
          end
          2'b11: begin
            if (cnt_q == 2'd2) begin
              instr0_p1 <= instr1_p1;
              addr0_p1  <= addr1_p1;
              instr1_p1 <= instr_p0;
              addr1_p1  <= addr_q;
            end else begin
              instr0_p1 <= instr_p0;
              addr0_p1  <= addr_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder; the inverse of the core's immediate decode path. It accepts decoded instruction fields (opcode, registers, funct, signed immediate) over a valid/ready handshake. It scatters the immediate into the format-correct bit positions and emits 32-bit instruction words, each tagged with a sequential word address. The bench program loader and the boot-image builder use it to fill instruction memory.

## Interface
Parameters:
- ADDR_W, 10, width of the word address counter.
- BASE_ADDR, 0, first word address emitted after reset or clear.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous restart: flush buffer, address to BASE_ADDR, clear done/err/err_cnt.
- in_valid  in  1  input fields valid.
- in_ready  out  1  encoder can accept.
- in_opcode  in  7  RV32I major opcode.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3; in_funct7  in  7.
- in_imm  in  32  signed immediate, byte offset for B/J, full value for U.
- in_last  in  1  marks final instruction of the image.
- out_valid  out  1; out_ready  in  1.
- out_instr  out  32  encoded word.
- out_addr  out  ADDR_W  word address of out_instr.
- done  out  1  image fully drained.
- err  out  1  sticky encode error.
- err_cnt  out  8  saturating error count.

## Operation
- Encoding by opcode:
  - U (0110111, 0010111): {imm[31:12], rd, op}.
  - J (1101111): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - I (1100111, 0010011, 0000011): {imm[11:0], rs1, f3, rd, op}.
    - Shift form (0010011 with f3 = 001/101): {funct7, imm[4:0], rs1, f3, rd, op}.
  - S (0100011): {imm[11:5], rs2, rs1, f3, imm[4:0], op}.
  - B (1100011): {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op}.
  - R (0110011): {funct7, rs2, rs1, f3, rd, op}.
  - Any other opcode: emit NOP 32'h00000013 and flag an error.
- Error handling:
  - An error sets err and increments err_cnt, which saturates at 255.
  - The word is still emitted, with truncated fields.
- Address:
  - Increments by 1 per accepted input.
  - Wraps modulo 2^ADDR_W.
- FSM states:
  - LOAD: accepting. Accepting an input with in_last = 1 moves to DRAIN.
  - DRAIN: in_ready = 0. When the buffer is empty, move to DONE.
  - DONE: done = 1, in_ready = 0. clear moves to LOAD.
- clear: acts from any state; overrides a same-cycle in_valid, which is not accepted.
- in_ready: gated low in the same cycle clear is high.

## Timing
- Reset values:
  - out_valid = 0, done = 0, err = 0, err_cnt = 0.
  - out_addr = BASE_ADDR, out_instr = 0.
  - in_ready = 1, state LOAD.
- Latency: 1 cycle from accept to out_valid when the buffer is empty.
- Buffering:
  - 2-entry skid buffer; in_ready = not full, registered.
  - Sustains 1 word/cycle while out_ready is high.
- Output handshake:
  - Transfer occurs on out_valid && out_ready.
  - out_instr and out_addr are held stable while out_valid && !out_ready.
  - Ordering is strictly FIFO.
- Accept and output transfer in the same cycle when full: legal, occupancy unchanged.
- rst_n asserted mid-stream discards buffered words immediately; no partial output.

## Configuration
- IMM_CHECK_EN defined: range and alignment checks are enabled and flag err:
  - U: imm[11:0] must be 0.
  - J: imm must be signed 21-bit and even.
  - I/S: imm must be signed 12-bit.
  - B: imm must be signed 13-bit and even.
  - Shifts: imm must be 0..31.
- IMM_CHECK_EN undefined: no immediate checks; only unknown opcodes flag err.

## Structure
- Shared package riscv_pkg:
  - Opcode constants (OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG).
  - Format enum (FMT_U, FMT_J, FMT_I, FMT_S, FMT_B, FMT_R).
  - NOP constant.
- Sub-module imm_scatter: combinational format decode plus immediate placement plus check flags. The top level holds the FSM, address counter, skid buffer and error counters.

## Test plan
- ADDI x1,x0,-1 after reset (op 0010011, rd 1, imm -1) -> out_instr 0xFFF00093, out_addr 0, one cycle after accept.
- BEQ x1,x2,-4 -> 0xFE208EE3.
- JAL x1,2048 -> 0x001000EF.
- LUI x5,0x12345000 -> 0x123452B7.
- ADDI x0,x0,2048:
  - With IMM_CHECK_EN -> out_instr 0x80000013, err = 1, err_cnt = 1.
  - Without -> err = 0.
- out_ready held low, 3 inputs offered -> in_ready drops after 2 accepts. Release out_ready -> addresses 0,1,2 emitted in order, none lost.
- Last input with in_last = 1 -> DRAIN, then done = 1 after the final transfer, with in_ready = 0. clear -> done = 0, next word at BASE_ADDR. rst_n pulsed mid-stream -> out_valid = 0 immediately.
